// File: rtl/output_controller_pkg.sv
// Shared definitions for the decoder's controllers: top-FSM state codes and frame geometry.
// Also holds the read-credit helper used by the stream edges that drain a BRAM.
package output_controller_pkg;

  localparam int unsigned CODE_LENGTH = 1024;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned STATE_WIDTH = 10;

  localparam logic [STATE_WIDTH-1:0] IDLE_STATE   = 10'd0;
  localparam logic [STATE_WIDTH-1:0] INPUT_STATE  = 10'd1;
  localparam logic [STATE_WIDTH-1:0] INIT_STATE   = 10'd2;
  localparam logic [STATE_WIDTH-1:0] DECODE_STATE = 10'd4;
  localparam logic [STATE_WIDTH-1:0] OUTPUT_STATE = 10'd8;

  // Words buffered plus in flight, minus the one leaving this cycle, must leave room
  // for the read being considered; counting the pop keeps one beat per cycle.
  function automatic logic read_credit_ok(input logic [1:0] count, input logic inflight,
                                          input logic pop);
    logic [2:0] pending;
    pending = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return pending < 3'd2;
  endfunction

endpackage

// File: rtl/output_controller_skid_fifo2.sv
// Two-entry FIFO with synchronous flush, used to absorb BRAM read latency on a stream edge.
// Head data is valid whenever the count is non-zero; push and pop may coincide.
module skid_fifo2 #(
  parameter int unsigned Width = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_empty
);

  logic [Width-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  // Producers are expected to hold off via credits; a push into a full FIFO loses data.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush) begin
      assert (!(i_push && (r_count == 2'd2)))
        else $error("skid_fifo2: push into full FIFO");
    end
  end

  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_count = r_count;
    o_empty = (r_count == 2'd0);
  end

endmodule

// File: rtl/output_controller.sv
// Drains the decoded-bit result BRAM as one AXI4-Stream frame while the top FSM is in
// OUTPUT_STATE; a 2-entry skid FIFO hides the one-cycle BRAM read latency.
module output_controller
  import output_controller_pkg::*;
#(
  parameter int unsigned CODE_LENGTH = output_controller_pkg::CODE_LENGTH,
  parameter int unsigned DATA_WIDTH  = output_controller_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned STATE_WIDTH = output_controller_pkg::STATE_WIDTH,
  parameter logic [STATE_WIDTH-1:0] OUTPUT_STATE = output_controller_pkg::OUTPUT_STATE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state,
  output logic [ADDR_WIDTH-1:0]  addr_to_result_bram,
  output logic                   enable_to_result_bram,
  input  logic [DATA_WIDTH-1:0]  data_from_result_bram,
  output logic                   maxis_tvalid,
  input  logic                   maxis_tready,
  output logic [DATA_WIDTH-1:0]  maxis_tdata,
  output logic                   maxis_tlast,
  output logic                   done
);

  localparam int unsigned WORD_COUNT = CODE_LENGTH / DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] WordCountW = WORD_COUNT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LastPtr    = WordCountW - 1'b1;

  // One extra bit so the pointer can rest at WORD_COUNT; it doubles as the issued count.
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_inflight;
  logic                  r_last_flag;
  logic                  r_frame_sent;
  logic                  r_done;

  logic                  w_active;
  logic                  w_clear;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_last_hs;
  logic                  w_fifo_empty;
  logic [1:0]            w_fifo_count;
  logic [DATA_WIDTH:0]   w_head;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;

  assign w_active    = (state == OUTPUT_STATE);
  assign w_clear     = reset || !w_active;
  assign w_head_data = w_head[DATA_WIDTH:1];
  assign w_head_last = w_head[0];
  assign w_pop       = !w_fifo_empty && maxis_tready;
  assign w_last_hs   = w_pop && w_head_last;

  assign w_issue = !w_clear && !r_frame_sent && (r_rd_ptr < WordCountW) &&
                   read_credit_ok(w_fifo_count, r_inflight, w_pop);

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_rd_ptr     <= '0;
      r_inflight   <= 1'b0;
      r_last_flag  <= 1'b0;
      r_frame_sent <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_inflight   <= w_issue;
      r_last_flag  <= w_issue && (r_rd_ptr == LastPtr);
      r_frame_sent <= r_frame_sent || w_last_hs;
      r_done       <= w_last_hs;
    end
  end

  skid_fifo2 #(
    .Width(DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk  (clk),
    .i_reset(reset),
    .i_flush(!w_active),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_data ({data_from_result_bram, r_last_flag}),
    .o_data (w_head),
    .o_count(w_fifo_count),
    .o_empty(w_fifo_empty)
  );

  always_comb begin
    addr_to_result_bram   = r_rd_ptr[ADDR_WIDTH-1:0];
    enable_to_result_bram = w_issue;
    maxis_tvalid          = !w_fifo_empty;
    maxis_tdata           = w_fifo_empty ? '0 : w_head_data;
    maxis_tlast           = !w_fifo_empty && w_head_last;
    done                  = r_done;
  end

endmodule

// File: tb/tb_output_controller.sv
// Directed bench for output_controller: BRAM model with one-cycle read latency, stream
// monitor counting beats/order/stability, and immediate-assertion checks per step.
module tb_output_controller;
  import output_controller_pkg::*;

  localparam int unsigned WC = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] state = IDLE_STATE;
  logic [6:0] addr;
  logic       en;
  logic [7:0] bram_q = 8'h00;
  logic       tvalid;
  logic       tready = 1'b0;
  logic [7:0] tdata;
  logic       tlast;
  logic       done;
  logic [7:0] mem [WC];

  int checks = 0;
  int failures = 0;
  int k, nbeats, first_k, last_k, done_k, ndone, nreads;
  int order_err, tlast_err, stab_err, addr_err;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  output_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .state                (state),
    .addr_to_result_bram  (addr),
    .enable_to_result_bram(en),
    .data_from_result_bram(bram_q),
    .maxis_tvalid         (tvalid),
    .maxis_tready         (tready),
    .maxis_tdata          (tdata),
    .maxis_tlast          (tlast),
    .done                 (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en) bram_q <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic logic ready_for(input int mode, input int kk);
    case (mode)
      1:       return (kk % 4 == 0) || (kk % 4 == 3);
      2:       return kk >= 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_counters();
    k = 0; nbeats = 0; first_k = -1; last_k = -1; done_k = -1; ndone = 0; nreads = 0;
    order_err = 0; tlast_err = 0; stab_err = 0; addr_err = 0;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
  endtask

  // Called 1 time unit after a negedge; samples, then advances to the next negedge.
  task automatic step(input int mode);
    logic hs;
    if (en === 1'b1) begin
      if (addr !== nreads[6:0]) addr_err++;
      nreads++;
    end
    if (done === 1'b1) begin
      ndone++;
      done_k = k;
    end
    hs = (tvalid === 1'b1) && (tready === 1'b1);
    if (tvalid === 1'b1) begin
      if (first_k < 0) first_k = k;
      if (prev_stall && ((tdata !== prev_data) || (tlast !== prev_last))) stab_err++;
      if (hs) begin
        if (tdata !== nbeats[7:0]) order_err++;
        if (tlast !== (nbeats == WC - 1)) tlast_err++;
        if (tlast === 1'b1) last_k = k;
        nbeats++;
      end
    end else if (prev_stall) begin
      stab_err++;
    end
    prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
    prev_data  = tdata;
    prev_last  = tlast;
    k++;
    @(negedge clk);
    tready = ready_for(mode, k);
    #1;
  endtask

  task automatic enter(input int mode);
    @(negedge clk);
    clear_counters();
    state  = OUTPUT_STATE;
    tready = ready_for(mode, 0);
    #1;
  endtask

  task automatic leave();
    @(negedge clk);
    state  = IDLE_STATE;
    tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_tvalid", tvalid, 0);
    check("idle_enable", en, 0);
  endtask

  task automatic run_until_done(input int mode, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ndone > 0 && k > done_k + 3) break;
      step(mode);
    end
  endtask

  initial begin
    int abort_done;
    for (int i = 0; i < WC; i++) mem[i] = i[7:0];

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_done", done, 0);
    check("rst_enable", en, 0);
    @(negedge clk);
    reset = 1'b0;

    // Straight frame, then 15 cycles held in OUTPUT_STATE after done
    enter(0);
    check("s_first_en", en, 1);
    check("s_first_addr", addr, 0);
    for (int i = 0; i < 145; i++) step(0);
    check("s_beats", nbeats, 128);
    check("s_first_tvalid_k", first_k, 2);
    check("s_last_k", last_k, 129);
    check("s_done_k", done_k, 130);
    check("s_done_count", ndone, 1);
    check("s_order_err", order_err, 0);
    check("s_tlast_err", tlast_err, 0);
    check("s_reads", nreads, 128);
    check("s_addr_err", addr_err, 0);
    check("pd_tvalid", tvalid, 0);
    check("pd_done", done, 0);
    check("pd_enable", en, 0);
    leave();

    // Backpressure 1,0,0,1
    enter(1);
    run_until_done(1, 600);
    check("bp_beats", nbeats, 128);
    check("bp_order_err", order_err, 0);
    check("bp_stab_err", stab_err, 0);
    check("bp_tlast_err", tlast_err, 0);
    check("bp_done_count", ndone, 1);
    check("bp_reads", nreads, 128);
    check("bp_addr_err", addr_err, 0);
    leave();

    // Stall at start for 20 cycles
    enter(2);
    while (k < 19) step(2);
    check("st_reads_stalled", nreads, 2);
    check("st_enable_low", en, 0);
    check("st_tvalid", tvalid, 1);
    check("st_tdata_head", tdata, 0);
    run_until_done(2, 400);
    check("st_beats", nbeats, 128);
    check("st_order_err", order_err, 0);
    check("st_stab_err", stab_err, 0);
    check("st_done_count", ndone, 1);
    check("st_reads", nreads, 128);
    leave();

    // Abort after 50 beats, then a full frame
    enter(0);
    while (nbeats < 50 && k < 200) step(0);
    check("ab_beats_before", nbeats, 50);
    state = IDLE_STATE;
    #1;
    check("ab_enable_now", en, 0);
    @(negedge clk);
    #1;
    check("ab_tvalid", tvalid, 0);
    abort_done = ndone;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) abort_done++;
      @(negedge clk);
      #1;
    end
    check("ab_no_done", abort_done, 0);
    enter(0);
    check("ab2_first_addr", addr, 0);
    run_until_done(0, 200);
    check("ab2_beats", nbeats, 128);
    check("ab2_order_err", order_err, 0);
    check("ab2_first_tvalid_k", first_k, 2);
    check("ab2_done_count", ndone, 1);
    leave();

    // Synchronous reset pulse at beat 70 with state held
    enter(0);
    while (nbeats < 70 && k < 200) step(0);
    check("rs_beats_before", nbeats, 70);
    reset = 1'b1;
    #1;
    check("rs_enable_in_reset", en, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rs_tvalid_after", tvalid, 0);
    check("rs_done_after", done, 0);
    clear_counters();
    check("rs_restart_en", en, 1);
    check("rs_restart_addr", addr, 0);
    run_until_done(0, 200);
    check("rs_beats", nbeats, 128);
    check("rs_order_err", order_err, 0);
    check("rs_first_tvalid_k", first_k, 2);
    check("rs_last_k", last_k, 129);
    check("rs_done_count", ndone, 1);
    leave();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
